// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Each CPU request is latched in IDLE and then resolved in LOOKUP.
// A miss goes through an optional one-cycle WRITEBACK of the dirty victim line.
// It then takes a one-cycle REFILL and returns to LOOKUP, which hits.
module dcache_wb #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cpu_req_valid,
  input  logic                            cpu_req_we,
  input  logic [WORD_SIZE-1:0]            cpu_req_addr,
  input  logic [WORD_SIZE-1:0]            cpu_req_wdata,
  output logic                            cpu_ready,
  output logic                            cpu_resp_valid,
  output logic [WORD_SIZE-1:0]            cpu_resp_rdata,
  output logic [WORD_SIZE-1:0]            mem_rd_ptr,
  input  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_rd_block,
  output logic [WORD_SIZE-1:0]            mem_wr_ptr,
  output logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_wr_block,
  output logic                            mem_wr_en
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

  state_t                 state_reg;
  logic                   req_we_reg;
  logic [WORD_SIZE-1:0]   req_addr_reg;
  logic [WORD_SIZE-1:0]   req_wdata_reg;
  logic [NUM_LINES-1:0]   valid_reg;
  logic [NUM_LINES-1:0]   dirty_reg;

  // Tag and data storage are deliberately left unreset; valid_reg guards them.
  logic [TAG_W-1:0]       tag_arr  [NUM_LINES];
  logic [WORD_SIZE-1:0]   data_arr [NUM_LINES][BLOCK_SIZE];

  logic [OFF_W-1:0]       req_off;
  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;

  assign req_off = req_addr_reg[OFF_W-1:0];
  assign req_idx = req_addr_reg[OFF_W +: IDX_W];
  assign req_tag = req_addr_reg[WORD_SIZE-1 -: TAG_W];
  assign hit     = valid_reg[req_idx] && (tag_arr[req_idx] == req_tag);

  assign cpu_ready  = (state_reg == IDLE);
  assign mem_wr_en  = (state_reg == WRITEBACK);
  assign mem_rd_ptr = {req_tag, req_idx, {OFF_W{1'b0}}};
  // The victim tag is only meaningful in WRITEBACK.
  // It is forced to zero elsewhere so the pointer never carries X from unwritten tags.
  assign mem_wr_ptr = (state_reg == WRITEBACK) ?
                      {tag_arr[req_idx], req_idx, {OFF_W{1'b0}}} : '0;

  // Pack the indexed line into the memory block layout.
  // Word 0 sits in the most significant bits.
  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_wr_pack
    assign mem_wr_block[(BLOCK_SIZE-gi)*WORD_SIZE-1 -: WORD_SIZE] = data_arr[req_idx][gi];
  end

  // Control FSM: request latch, line status bits and registered CPU response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      req_we_reg     <= 1'b0;
      req_addr_reg   <= '0;
      req_wdata_reg  <= '0;
      valid_reg      <= '0;
      dirty_reg      <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_req_valid) begin
            req_we_reg    <= cpu_req_we;
            req_addr_reg  <= cpu_req_addr;
            req_wdata_reg <= cpu_req_wdata;
            state_reg     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we_reg) begin
              dirty_reg[req_idx] <= 1'b1;
            end else begin
              cpu_resp_rdata <= data_arr[req_idx][req_off];
            end
            cpu_resp_valid <= 1'b1;
            state_reg      <= IDLE;
          end else if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
            state_reg <= WRITEBACK;
          end else begin
            state_reg <= REFILL;
          end
        end
        WRITEBACK: begin
          state_reg <= REFILL;
        end
        REFILL: begin
          valid_reg[req_idx] <= 1'b1;
          dirty_reg[req_idx] <= 1'b0;
          state_reg          <= LOOKUP;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Line storage updates: the whole-block refill, and the store-hit word merge.
  always_ff @(posedge clk) begin
    if (state_reg == REFILL) begin
      tag_arr[req_idx] <= req_tag;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        data_arr[req_idx][k] <= mem_rd_block[(BLOCK_SIZE-k)*WORD_SIZE-1 -: WORD_SIZE];
      end
    end else if (state_reg == LOOKUP && hit && req_we_reg) begin
      data_arr[req_idx][req_off] <= req_wdata_reg;
    end
  end

endmodule
